dmi_core_req_ctrl: RTL and testbench
====================================

DMI_CORE_REQ_CTRL -- requirements
Module: dmi_core_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the DMI address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the DMI data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the request timeout in clk cycles; legal range 1..65535.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, core clock; rst input 1, synchronous active-high reset.
REQ-005 reg_en input 1: single-cycle pulse, DMI access strobe from the core-side synchronizer.
REQ-006 reg_wr_en input 1: pulse coincident with reg_en; 1 = write, 0 = read.
REQ-007 reg_addr input ADDR_W: address from the JTAG domain, stable while reg_en pulses.
REQ-008 reg_wdata input DATA_W: write data from the JTAG domain, stable while reg_en pulses.
REQ-009 clr_sticky input 1: dmireset; clears the sticky status.
REQ-010 dm_req_valid output 1, dm_req_ready input 1: request handshake to the debug module.
REQ-011 dm_req_addr output ADDR_W, dm_req_wdata output DATA_W, dm_req_wr output 1: request payload.
REQ-012 dm_rsp_valid input 1, dm_rsp_ready output 1, dm_rsp_rdata input DATA_W, dm_rsp_err input 1: response handshake from the debug module.
REQ-013 rd_data output DATA_W: last read data, held stable for JTAG capture.
REQ-014 status output 2: DMI op status; 0 = ok, 2 = failed, 3 = busy/overrun.
REQ-015 busy output 1: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, and WAIT_RSP.
REQ-017 In IDLE, reg_en at cycle N SHALL capture addr, wdata, and wr into payload registers and enter REQ; dm_req_valid SHALL be high from cycle N+1.
REQ-018 In REQ, dm_req_valid=1 with a stable payload until dm_req_ready=1; on that cycle the FSM SHALL go to WAIT_RSP.
REQ-019 In WAIT_RSP, dm_rsp_ready=1; on dm_rsp_valid the FSM SHALL return to IDLE.
REQ-020 On that same dm_rsp_valid cycle, for a read, rd_data SHALL load dm_rsp_rdata.
REQ-021 On that same cycle, status SHALL be set to 2 if dm_rsp_err=1, else left unchanged.
REQ-022 Write responses SHALL NOT modify rd_data.
REQ-023 dm_rsp_valid outside WAIT_RSP SHALL be ignored, with dm_rsp_ready=0.
REQ-024 reg_en while busy SHALL be dropped, set status=3 (sticky), and leave payload and FSM untouched.
REQ-025 status SHALL be sticky: non-zero values persist until clr_sticky; a higher code SHALL overwrite a lower one, never the reverse.
REQ-026 clr_sticky SHALL set status=0 on the next edge; if an overrun or error occurs in the same cycle, the new code wins.
REQ-027 dm_req_valid SHALL never deassert before acceptance, except on timeout or rst.

Reset
REQ-028 On rst, state SHALL be IDLE, and the following SHALL be 0: dm_req_valid, dm_rsp_ready, payload registers, rd_data, status, busy, and the timeout counter.
REQ-029 rst mid-transaction SHALL abandon the request on the next edge with no status update.

Configuration
REQ-030 Macro DMI_REQ_TIMEOUT_EN defined: a counter SHALL clear on entering REQ and increment each cycle in REQ/WAIT_RSP.
REQ-031 With DMI_REQ_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE, drop dm_req_valid/dm_rsp_ready, and set status=2.
REQ-032 With DMI_REQ_TIMEOUT_EN defined, dm_rsp_valid on the expiry cycle SHALL take priority, completing normally.
REQ-033 Macro DMI_REQ_TIMEOUT_EN undefined: no counter logic SHALL exist, and the FSM SHALL wait indefinitely.

Structure
REQ-034 The shared package dmi_pkg SHALL hold the FSM state enum and the status code constants (DMI_ST_OK=0, DMI_ST_FAIL=2, DMI_ST_BUSY=3).
REQ-035 Sub-module dmi_timeout_ctr (clear, enable, expired) SHALL be instantiated only under DMI_REQ_TIMEOUT_EN.

Verification
REQ-036 Read: reg_en with wr=0, addr=0x11; ready 2 cycles later; rsp rdata=0xDEADBEEF one cycle after that -> dm_req_valid at N+1, rd_data=0xDEADBEEF, status=0, busy low after the response.
REQ-037 Write: addr=0x10, wdata=0x1; rsp_err=1 -> rd_data unchanged, status=2, held across the next ok transaction until clr_sticky.
REQ-038 Overrun: second reg_en while in WAIT_RSP -> status=3, payload unchanged, first transaction completes; clr_sticky -> status=0.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=8): never assert ready -> idle after 8 cycles, status=2, dm_req_valid low; rsp_valid on the expiry cycle -> normal completion.
REQ-040 rst asserted one cycle in WAIT_RSP -> all outputs 0 next edge; late dm_rsp_valid ignored.

Source files
------------

// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared FSM state type and DMI status codes for the core-side request controller
package dmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } dmi_state_e;

    localparam logic [1:0] DMI_ST_OK   = 2'd0;
    localparam logic [1:0] DMI_ST_FAIL = 2'd2;
    localparam logic [1:0] DMI_ST_BUSY = 2'd3;

    // Sticky status only ever moves up in severity.
    function automatic logic [1:0] status_max(input logic [1:0] a, input logic [1:0] b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/dmi_core_req_ctrl_if.sv
// rtl/dmi_core_req_ctrl_if.sv - request/response handshake between the DMI controller and the debug module
interface dmi_core_req_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              dm_req_valid;
    logic              dm_req_ready;
    logic [ADDR_W-1:0] dm_req_addr;
    logic [DATA_W-1:0] dm_req_wdata;
    logic              dm_req_wr;
    logic              dm_rsp_valid;
    logic              dm_rsp_ready;
    logic [DATA_W-1:0] dm_rsp_rdata;
    logic              dm_rsp_err;

    modport master (
        output dm_req_valid, dm_req_addr, dm_req_wdata, dm_req_wr, dm_rsp_ready,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err
    );

    modport slave (
        input  dm_req_valid, dm_req_addr, dm_req_wdata, dm_req_wr, dm_rsp_ready,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err
    );
endinterface

// File: rtl/dmi_timeout_ctr.sv
// rtl/dmi_timeout_ctr.sv - request timeout counter; expired is high on the last allowed busy cycle
module dmi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign expired = enable && (cnt == LIMIT);
endmodule

// File: rtl/dmi_core_req_ctrl.sv
// rtl/dmi_core_req_ctrl.sv - turns core-side DMI strobes into debug-module requests with sticky status
// Optional request timeout enabled by defining DMI_REQ_TIMEOUT_EN.
module dmi_core_req_ctrl
    import dmi_pkg::*;
#(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              clr_sticky,
    dmi_core_req_ctrl_if.master dm,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        status,
    output logic              busy
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    dmi_state_e        state;
    logic              req_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] pay_addr;
    logic [DATA_W-1:0] pay_wdata;
    logic              pay_wr;
    logic              expired;

    logic       rsp_fire;
    logic       overrun;
    logic       timeout_hit;
    logic [1:0] status_base;
    logic [1:0] status_event;

`ifdef DMI_REQ_TIMEOUT_EN
    dmi_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE && reg_en),
        .enable  (state != ST_IDLE),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign rsp_fire    = (state == ST_WAIT_RSP) && dm.dm_rsp_valid;
    assign overrun     = reg_en && (state != ST_IDLE);
    // A response arriving on the expiry cycle still completes normally.
    assign timeout_hit = expired && !rsp_fire;

    always_comb begin
        status_base  = clr_sticky ? DMI_ST_OK : status;
        status_event = DMI_ST_OK;
        if ((rsp_fire && dm.dm_rsp_err) || timeout_hit) status_event = DMI_ST_FAIL;
        if (overrun) status_event = DMI_ST_BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_valid <= 1'b0;
            rsp_ready <= 1'b0;
            pay_addr  <= '0;
            pay_wdata <= '0;
            pay_wr    <= 1'b0;
            rd_data   <= '0;
            status    <= DMI_ST_OK;
        end else begin
            status <= status_max(status_base, status_event);
            unique case (state)
                ST_IDLE: begin
                    if (reg_en) begin
                        pay_addr  <= reg_addr;
                        pay_wdata <= reg_wdata;
                        pay_wr    <= reg_wr_en;
                        req_valid <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (timeout_hit) begin
                        req_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (dm.dm_req_ready) begin
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_fire) begin
                        if (!pay_wr) rd_data <= dm.dm_rsp_rdata;
                        rsp_ready <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        rsp_ready <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    req_valid <= 1'b0;
                    rsp_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = (state != ST_IDLE);
    assign dm.dm_req_valid = req_valid;
    assign dm.dm_rsp_ready = rsp_ready;
    assign dm.dm_req_addr  = pay_addr;
    assign dm.dm_req_wdata = pay_wdata;
    assign dm.dm_req_wr    = pay_wr;
endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// tb/tb_dmi_core_req_ctrl.sv - directed self-checking bench for dmi_core_req_ctrl
module tb_dmi_core_req_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        reg_en;
    logic        reg_wr_en;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        clr_sticky;
    logic [31:0] rd_data;
    logic [1:0]  status;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    dmi_core_req_ctrl_if #(.ADDR_W(7), .DATA_W(32)) dm_bus ();

    dmi_core_req_ctrl #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_en     (reg_en),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .clr_sticky (clr_sticky),
        .dm         (dm_bus.master),
        .rd_data    (rd_data),
        .status     (status),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [6:0] addr, input logic [31:0] wdata);
        reg_en    = 1'b1;
        reg_wr_en = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        tick();
        reg_en    = 1'b0;
        reg_wr_en = 1'b0;
    endtask

    task automatic accept();
        dm_bus.dm_req_ready = 1'b1;
        tick();
        dm_bus.dm_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        dm_bus.dm_rsp_valid = 1'b1;
        dm_bus.dm_rsp_rdata = rdata;
        dm_bus.dm_rsp_err   = err;
        tick();
        dm_bus.dm_rsp_valid = 1'b0;
        dm_bus.dm_rsp_err   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reg_en = 1'b0; reg_wr_en = 1'b0; reg_addr = '0; reg_wdata = '0; clr_sticky = 1'b0;
        dm_bus.dm_req_ready = 1'b0; dm_bus.dm_rsp_valid = 1'b0;
        dm_bus.dm_rsp_rdata = '0;   dm_bus.dm_rsp_err   = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_req_valid", dm_bus.dm_req_valid, 0);
        check("rst_rsp_ready", dm_bus.dm_rsp_ready, 0);
        check("rst_payload",   {dm_bus.dm_req_addr, dm_bus.dm_req_wdata, dm_bus.dm_req_wr}, 0);
        check("rst_rd_data",   rd_data, 0);
        check("rst_status",    status, 0);
        check("rst_busy",      busy, 0);

        // Read of 0x11: ready two cycles after the strobe, response one cycle later.
        start_req(1'b0, 7'h11, 32'h0000_0055);
        check("rd_valid_n1", dm_bus.dm_req_valid, 1);
        check("rd_addr",     dm_bus.dm_req_addr, 7'h11);
        check("rd_wr",       dm_bus.dm_req_wr, 0);
        check("rd_busy",     busy, 1);
        dm_bus.dm_rsp_valid = 1'b1;
        dm_bus.dm_rsp_rdata = 32'h7777_7777;
        tick();
        dm_bus.dm_rsp_valid = 1'b0;
        check("rd_valid_held", dm_bus.dm_req_valid, 1);
        check("rd_rsp_in_req_ignored", rd_data, 0);
        check("rd_rsp_ready_in_req", dm_bus.dm_rsp_ready, 0);
        accept();
        check("rd_valid_drop", dm_bus.dm_req_valid, 0);
        check("rd_rsp_ready",  dm_bus.dm_rsp_ready, 1);
        respond(32'hDEAD_BEEF, 1'b0);
        check("rd_data",       rd_data, 32'hDEAD_BEEF);
        check("rd_status",     status, 0);
        check("rd_busy_after", busy, 0);
        check("rd_rsp_ready_after", dm_bus.dm_rsp_ready, 0);

        // Response while idle is ignored.
        respond(32'h1111_1111, 1'b1);
        check("idle_rsp_rd_data", rd_data, 32'hDEAD_BEEF);
        check("idle_rsp_status",  status, 0);

        // Write with error: rd_data untouched, status sticks across a clean read.
        start_req(1'b1, 7'h10, 32'h0000_0001);
        check("wr_wdata", dm_bus.dm_req_wdata, 32'h1);
        check("wr_wr",    dm_bus.dm_req_wr, 1);
        accept();
        respond(32'h1234_5678, 1'b1);
        check("wr_rd_data_kept", rd_data, 32'hDEAD_BEEF);
        check("wr_err_status",   status, 2);
        start_req(1'b0, 7'h12, 32'h0);
        accept();
        respond(32'hCAFE_F00D, 1'b0);
        check("ok_after_err_rd_data", rd_data, 32'hCAFE_F00D);
        check("ok_after_err_status",  status, 2);
        pulse_clr();
        check("clr_status", status, 0);

        // Overrun in WAIT_RSP: payload kept, first transaction completes; error cannot downgrade 3.
        start_req(1'b1, 7'h22, 32'h0000_00A5);
        accept();
        start_req(1'b0, 7'h33, 32'h0000_0099);
        check("ovr_status",   status, 3);
        check("ovr_addr",     dm_bus.dm_req_addr, 7'h22);
        check("ovr_wdata",    dm_bus.dm_req_wdata, 32'hA5);
        check("ovr_busy",     busy, 1);
        check("ovr_rsp_rdy",  dm_bus.dm_rsp_ready, 1);
        respond(32'h0, 1'b1);
        check("ovr_done_busy",   busy, 0);
        check("ovr_err_no_down", status, 3);
        pulse_clr();
        check("ovr_clr", status, 0);

        // clr_sticky coincident with an overrun: the new code wins.
        start_req(1'b0, 7'h01, 32'h0);
        clr_sticky = 1'b1;
        start_req(1'b0, 7'h02, 32'h0);
        clr_sticky = 1'b0;
        check("clr_vs_ovr", status, 3);
        check("clr_vs_ovr_addr", dm_bus.dm_req_addr, 7'h01);
        accept();
        respond(32'h0000_0042, 1'b0);
        check("clr_vs_ovr_rd", rd_data, 32'h42);
        pulse_clr();

        // Reset while waiting for a response abandons it; a late response is ignored.
        start_req(1'b0, 7'h44, 32'h0000_0003);
        accept();
        start_req(1'b0, 7'h45, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req_valid", dm_bus.dm_req_valid, 0);
        check("mid_rst_rsp_ready", dm_bus.dm_rsp_ready, 0);
        check("mid_rst_payload",   {dm_bus.dm_req_addr, dm_bus.dm_req_wdata, dm_bus.dm_req_wr}, 0);
        check("mid_rst_rd_data",   rd_data, 0);
        check("mid_rst_status",    status, 0);
        check("mid_rst_busy",      busy, 0);
        respond(32'h0000_0999, 1'b0);
        check("late_rsp_rd_data", rd_data, 0);
        check("late_rsp_busy",    busy, 0);

`ifdef DMI_REQ_TIMEOUT_EN
        // Never ready: busy for 8 cycles, then idle with status 2.
        start_req(1'b0, 7'h50, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("to_busy_before", busy, 1);
        check("to_valid_before", dm_bus.dm_req_valid, 1);
        tick();
        check("to_busy_after",  busy, 0);
        check("to_valid_after", dm_bus.dm_req_valid, 0);
        check("to_status",      status, 2);
        pulse_clr();
        // Response on the expiry cycle completes normally.
        start_req(1'b0, 7'h51, 32'h0);
        accept();
        for (int i = 0; i < 6; i++) tick();
        check("to_edge_busy", busy, 1);
        respond(32'hABCD_0123, 1'b0);
        check("to_edge_rd_data", rd_data, 32'hABCD_0123);
        check("to_edge_status",  status, 0);
        check("to_edge_busy_after", busy, 0);
`else
        // Without the timeout the request is held indefinitely.
        start_req(1'b0, 7'h50, 32'h0);
        for (int i = 0; i < 300; i++) tick();
        check("no_to_busy",   busy, 1);
        check("no_to_valid",  dm_bus.dm_req_valid, 1);
        check("no_to_status", status, 0);
        accept();
        respond(32'hABCD_0123, 1'b0);
        check("no_to_rd_data", rd_data, 32'hABCD_0123);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
